// File: rtl/bcd_pkg.sv
// Shared types and decimal constants for the BCD digit-slice datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_MAX   = 4'd9;
    localparam bcd_digit_t  BCD_CORR  = 4'd6;
    localparam logic [4:0]  BCD_RADIX = 5'd10;

endpackage : bcd_pkg

// File: rtl/bcd_adder_if.sv
// Operand/result bundle of one BCD digit slice; master drives operands,
// slave (the adder) returns the registered result.
interface bcd_adder_if;
    import bcd_pkg::*;

    logic       in_valid;
    bcd_digit_t A;
    bcd_digit_t B;
    logic       Cin;
    bcd_digit_t S;
    logic       Cout;
    logic       out_valid;
    logic       err;

    modport master (
        output in_valid, A, B, Cin,
        input  S, Cout, out_valid, err
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output S, Cout, out_valid, err
    );

endinterface : bcd_adder_if

// File: rtl/bcd_correct.sv
// Combinational BCD digit add with decimal correction and illegal-operand flag.
module bcd_correct
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       carry,
    output logic       illegal
);

    logic [4:0] bin;

    // NOTE: every output gets a default before any branch so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        sum     = '0;
        carry   = 1'b0;
        illegal = (a > BCD_MAX) || (b > BCD_MAX);
        bin     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (!illegal) begin
            if (bin >= BCD_RADIX) begin
                // Adding 6 skips the six unused codes; the wrap drops the 16.
                sum   = bin[3:0] + BCD_CORR;
                carry = 1'b1;
            end else begin
                sum   = bin[3:0];
            end
        end
    end

endmodule : bcd_correct

// File: rtl/bcd_adder.sv
// Single-digit BCD adder: combinational correction followed by a one-cycle
// output register with a valid strobe.
module bcd_adder
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    bcd_adder_if.slave  bus
);

    bcd_digit_t sum_c;
    logic       carry_c;
    logic       illegal_c;

    bcd_correct u_correct (
        .a       (bus.A),
        .b       (bus.B),
        .cin     (bus.Cin),
        .sum     (sum_c),
        .carry   (carry_c),
        .illegal (illegal_c)
    );

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is asynchronous so outputs clear without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.S         <= '0;
            bus.Cout      <= 1'b0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.S         <= sum_c;
            bus.Cout      <= carry_c;
            bus.err       <= illegal_c;
            bus.out_valid <= 1'b1;
        end else begin
            // Result fields hold; only the strobe drops.
            bus.out_valid <= 1'b0;
        end
    end

endmodule : bcd_adder

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: directed corner cases, exhaustive legal
// sweep, randomized mix with illegal operands, and async reset behaviour.
module tb_bcd_adder;
    import bcd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_adder_if bus ();

    bcd_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the output register should currently show.
    int exp_s   = 0;
    int exp_c   = 0;
    int exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_ov);
        check({tag, ".S"},         32'(bus.S),         32'(exp_s));
        check({tag, ".Cout"},      32'(bus.Cout),      32'(exp_c));
        check({tag, ".err"},       32'(bus.err),       32'(exp_err));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
    endtask

    // Decimal reference: a digit result is just the base-10 split of the total.
    task automatic model(input int a, input int b, input int cin);
        if (a > 9 || b > 9) begin
            exp_err = 1; exp_s = 0; exp_c = 0;
        end else begin
            exp_err = 0;
            exp_s   = (a + b + cin) % 10;
            exp_c   = (a + b + cin) / 10;
        end
    endtask

    task automatic step(input string tag, input int a, input int b, input int cin, input bit v);
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.Cin      = cin[0];
        bus.in_valid = v;
        @(posedge clk);
        #1;
        if (v) model(a, b, cin);
        check_out(tag, v ? 1 : 0);
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.in_valid = 1'b0;

        // Held in reset across edges with live inputs: nothing may appear.
        for (int i = 0; i < 3; i++) begin
            bus.A = 4'($urandom_range(0, 15));
            bus.B = 4'($urandom_range(0, 15));
            bus.Cin = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check_out("reset_hold", 0);
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b1;

        step("add_4_5",    4, 5, 0, 1'b1);
        step("add_5_5",    5, 5, 0, 1'b1);
        step("add_9_9_c",  9, 9, 1, 1'b1);
        step("add_0_0",    0, 0, 0, 1'b1);
        step("add_0_9_c",  0, 9, 1, 1'b1);
        step("illegal_10", 10, 3, 0, 1'b1);
        step("after_ill",  3, 3, 0, 1'b1);
        step("illegal_b",  2, 15, 1, 1'b1);
        step("add_9_1",    9, 1, 0, 1'b1);
        step("idle_hold",  7, 7, 1, 1'b0);
        step("idle_hold2", 12, 1, 0, 1'b0);

        // Exhaustive legal sweep, back-to-back at full throughput.
        for (int a = 0; a <= 9; a++)
            for (int b = 0; b <= 9; b++)
                for (int c = 0; c <= 1; c++)
                    step("exh", a, b, c, 1'b1);

        // Randomized mix: illegal codes and idle cycles interleaved.
        for (int i = 0; i < 400; i++)
            step("rnd", $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1), ($urandom_range(0, 3) != 0));

        // Async reset mid-cycle: outputs clear with no clock edge.
        step("pre_rst", 9, 9, 1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_s = 0; exp_c = 0; exp_err = 0;
        check_out("async_rst", 0);

        // Inputs sampled while in reset are dropped.
        bus.A = 4'd4; bus.B = 4'd5; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_drop", 0);
        #3 rst_n = 1'b1;
        step("post_rst_idle", 4, 5, 0, 1'b0);
        step("post_rst_add",  8, 7, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_adder
